ldpc_qc_enc_stream: RTL and testbench

LDPC_QC_ENC_STREAM -- requirements
Module: ldpc_qc_enc_stream

---
 rtl/ldpc_pkg.sv | 23 ++
 rtl/ldpc_gen_rom.sv | 31 +++
 rtl/ldpc_qc_enc_stream.sv | 180 ++++++++++++++++++
 tb/tb_ldpc_qc_enc_stream.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared defaults, encoder state type and the generator first-row table
// for the streaming quasi-cyclic LDPC encoder.
package ldpc_pkg;

    localparam int W_DEF  = 4;
    localparam int Z_DEF  = 16;
    localparam int KB_DEF = 4;
    localparam int PB_DEF = 2;

    typedef enum logic {
        ST_INFO   = 1'b0,
        ST_PARITY = 1'b1
    } enc_state_e;

    // First row of each info block column; each 16-bit segment is one circulant.
    localparam logic [KB_DEF-1:0][31:0] GEN_ROWS = {
        32'h0008_0100,
        32'h0100_0800,
        32'h4000_0020,
        32'h8000_0001
    };

endpackage

// File: rtl/ldpc_gen_rom.sv
// Combinational lookup of the generator first row for one info block column.
// Non-default geometries fall back to a synthetic single-bit-per-circulant table.
module ldpc_gen_rom
    import ldpc_pkg::*;
#(
    parameter int  Z  = Z_DEF,
    parameter int  KB = KB_DEF,
    parameter int  PB = PB_DEF,
    localparam int P  = PB * Z,
    localparam int IW = (KB > 1) ? $clog2(KB) : 1
) (
    input  logic [IW-1:0] idx_i,
    output logic [P-1:0]  row_o
);

    generate
        if (Z == Z_DEF && KB == KB_DEF && PB == PB_DEF) begin : g_table
            assign row_o = GEN_ROWS[idx_i];
        end else begin : g_synth
            always_comb begin
                row_o = '0;
                for (int s = 0; s < PB; s++) begin
                    for (int n = 0; n < Z; n++) begin
                        row_o[s*Z+n] = (n == ((int'(idx_i) * 3 + s * 5) % Z));
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ldpc_qc_enc_stream.sv
// Streaming systematic QC-LDPC encoder: passes info beats through with one
// cycle of latency while accumulating parity, then streams the parity beats.
module ldpc_qc_enc_stream
    import ldpc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int Z  = Z_DEF,
    parameter int KB = KB_DEF,
    parameter int PB = PB_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         err_len
);

    localparam int P     = PB * Z;
    localparam int BPB   = Z / W;
    localparam int PBT   = P / W;
    localparam int SUB_W = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int BLK_W = (KB > 1) ? $clog2(KB) : 1;
    localparam int PC_W  = $clog2(PBT + 1);

    enc_state_e       state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [PC_W-1:0]  par_cnt_q, par_cnt_d;
    logic [P-1:0]     row_q, row_d;
    logic [P-1:0]     parity_q, parity_d;
    logic [W-1:0]     m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             err_len_q, err_len_d;

    logic [BLK_W-1:0] blk_next;
    logic [P-1:0]     rom_row;
    logic [P-1:0]     row0;
    logic [P-1:0]     xor_acc;
    logic [P-1:0]     row_adv;
    logic             out_free;
    logic             info_last;

    // Rotate every Z-bit circulant segment by one position toward the LSB.
    function automatic logic [P-1:0] rot1(input logic [P-1:0] v);
        logic [P-1:0] r;
        r = '0;
        for (int s = 0; s < PB; s++) begin
            r[s*Z +: Z] = {v[s*Z], v[s*Z+1 +: Z-1]};
        end
        return r;
    endfunction

    assign blk_next  = (blk_q == BLK_W'(KB - 1)) ? '0 : blk_q + 1'b1;
    assign info_last = (blk_q == BLK_W'(KB - 1)) && (sub_q == SUB_W'(BPB - 1));
    assign out_free  = !m_valid_q || m_ready;

    ldpc_gen_rom #(.Z(Z), .KB(KB), .PB(PB)) u_rom (
        .idx_i (blk_next),
        .row_o (rom_row)
    );

    ldpc_gen_rom #(.Z(Z), .KB(KB), .PB(PB)) u_rom0 (
        .idx_i ('0),
        .row_o (row0)
    );

    // s_data[W-1] is the earliest info bit, so it uses the unrotated row.
    always_comb begin
        logic [P-1:0] cur;
        xor_acc = '0;
        cur     = row_q;
        for (int t = 0; t < W; t++) begin
            if (s_data[W-1-t]) begin
                xor_acc = xor_acc ^ cur;
            end
            cur = rot1(cur);
        end
        row_adv = cur;
    end

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        sub_d     = sub_q;
        par_cnt_d = par_cnt_q;
        row_d     = row_q;
        parity_d  = parity_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        err_len_d = 1'b0;
        s_ready   = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            ST_INFO: begin
                s_ready = out_free;
                if (s_valid && out_free) begin
                    m_data_d  = s_data;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    parity_d  = parity_q ^ xor_acc;
                    err_len_d = (s_last != info_last);
                    if (sub_q == SUB_W'(BPB - 1)) begin
                        sub_d = '0;
                        blk_d = blk_next;
                        row_d = rom_row;
                    end else begin
                        sub_d = sub_q + 1'b1;
                        row_d = row_adv;
                    end
                    if (info_last) begin
                        state_d   = ST_PARITY;
                        par_cnt_d = '0;
                    end
                end
            end
            ST_PARITY: begin
                if (m_valid_q && m_last_q && m_ready) begin
                    state_d   = ST_INFO;
                    parity_d  = '0;
                    row_d     = row0;
                    blk_d     = '0;
                    sub_d     = '0;
                    par_cnt_d = '0;
                end else if (out_free && par_cnt_q != PC_W'(PBT)) begin
                    m_data_d  = parity_q[P-1 -: W];
                    parity_d  = parity_q << W;
                    m_valid_d = 1'b1;
                    m_last_d  = (par_cnt_q == PC_W'(PBT - 1));
                    par_cnt_d = par_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_INFO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INFO;
            blk_q     <= '0;
            sub_q     <= '0;
            par_cnt_q <= '0;
            row_q     <= row0;
            parity_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            sub_q     <= sub_d;
            par_cnt_q <= par_cnt_d;
            row_q     <= row_d;
            parity_q  <= parity_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            err_len_q <= err_len_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign err_len = err_len_q;

endmodule

// File: tb/tb_ldpc_qc_enc_stream.sv
// Directed bench for ldpc_qc_enc_stream: codeword content, handshake,
// frame-length error pulses and mid-frame reset recovery.
module tb_ldpc_qc_enc_stream;

    localparam int W  = 4;
    localparam int Z  = 16;
    localparam int KB = 4;
    localparam int PB = 2;
    localparam int NB = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         err_len;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rom_tb [4] = '{32'h8000_0001, 32'h4000_0020, 32'h0100_0800, 32'h0008_0100};

    always #5 clk = ~clk;

    ldpc_qc_enc_stream #(.W(W), .Z(Z), .KB(KB), .PB(PB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .err_len (err_len)
    );

    // Golden parity: bit n (MSB-first within a segment) of g_{b*Z+j} is bit (n-j) mod Z of row b.
    function automatic logic [31:0] model_parity(input logic [63:0] info);
        logic [31:0] par;
        logic [31:0] g;
        logic [31:0] r0;
        int b, j, src;
        par = '0;
        for (int i = 0; i < 64; i++) begin
            if (info[63-i]) begin
                b  = i / Z;
                j  = i % Z;
                r0 = rom_tb[b];
                g  = '0;
                for (int s = 0; s < PB; s++) begin
                    for (int n = 0; n < Z; n++) begin
                        src = (n - j + Z) % Z;
                        g[s*Z+Z-1-n] = r0[s*Z+Z-1-src];
                    end
                end
                par = par ^ g;
            end
        end
        return par;
    endfunction

    // Drives one frame and collects the codeword, checking hold, s_ready, m_last and err_len per cycle.
    task automatic run_frame(input logic [63:0] info, input int slast_beat, input bit toggle,
                             output logic [95:0] cw, output int cycles, output int err_cnt);
        int   sent;
        int   nout;
        bit   exp_err;
        bit   prev_stall;
        bit   rdy_phase;
        logic [W-1:0] prev_d;
        logic prev_l;
        sent = 0; nout = 0; cycles = 0; err_cnt = 0;
        exp_err = 1'b0; prev_stall = 1'b0; rdy_phase = 1'b1;
        prev_d = '0; prev_l = 1'b0; cw = '0;
        while (nout < NB && cycles < 400) begin
            @(negedge clk);
            cycles++;
            tests_run++;
            if (err_len !== exp_err) begin
                tests_failed++;
                $display("FAIL err_len cycle %0d: got %b expected %b", cycles, err_len, exp_err);
            end
            if (err_len === 1'b1) err_cnt++;
            exp_err = 1'b0;
            if (prev_stall) begin
                tests_run++;
                if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
                    tests_failed++;
                    $display("FAIL stall_hold cycle %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             cycles, m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            m_ready   = toggle ? rdy_phase : 1'b1;
            rdy_phase = !rdy_phase;
            if (sent < 16) begin
                s_valid = 1'b1;
                s_data  = info[63-sent*4 -: 4];
                s_last  = (sent == slast_beat);
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
                s_last  = 1'b0;
            end
            #1;
            if (sent == 16) begin
                tests_run++;
                if (s_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL s_ready_parity cycle %0d: got %b expected 0", cycles, s_ready);
                end
            end
            if (s_valid && s_ready) begin
                exp_err = (s_last != (sent == 15));
                sent++;
            end
            if (m_valid && m_ready) begin
                cw[95-nout*4 -: 4] = m_data;
                tests_run++;
                if (m_last !== (nout == NB - 1)) begin
                    tests_failed++;
                    $display("FAIL m_last beat %0d: got %b expected %b", nout + 1, m_last, (nout == NB - 1));
                end
                nout++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
        if (nout < NB) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_timeout: got %0d beats expected %0d", nout, NB);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || err_len !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b d=%h l=%b e=%b r=%b expected 0 0 0 0 1",
                     m_valid, m_data, m_last, err_len, s_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_frame();
        logic [95:0] cw;
        int cyc, errs;
        run_frame(64'h0, 15, 1'b0, cw, cyc, errs);
        tests_run++;
        if (cw !== 96'h0) begin
            tests_failed++;
            $display("FAIL zero_codeword: got %h expected 0", cw);
        end
        tests_run++;
        if (cyc !== 25) begin
            tests_failed++;
            $display("FAIL zero_no_bubble: got %0d cycles expected 25", cyc);
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("FAIL zero_err_len: got %0d pulses expected 0", errs);
        end
    endtask

    task automatic test_single_bit();
        logic [63:0] info_tab [3] = '{64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0000_4000_0000_0000};
        logic [31:0] par_tab  [3] = '{32'h8000_0001, 32'h4000_8000, 32'h2000_0010};
        logic [95:0] cw;
        int cyc, errs;
        for (int k = 0; k < 3; k++) begin
            run_frame(info_tab[k], 15, 1'b0, cw, cyc, errs);
            tests_run++;
            if (cw !== {info_tab[k], par_tab[k]}) begin
                tests_failed++;
                $display("FAIL single_bit_%0d: got %h expected %h", k, cw, {info_tab[k], par_tab[k]});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] info;
        logic [95:0] cw;
        int cyc, errs;
        info = 64'hA5C3_0F96_1234_FEDC;
        run_frame(info, 15, 1'b1, cw, cyc, errs);
        tests_run++;
        if (cw !== {info, model_parity(info)}) begin
            tests_failed++;
            $display("FAIL backpressure_codeword: got %h expected %h", cw, {info, model_parity(info)});
        end
    endtask

    task automatic test_len_err();
        logic [63:0] info;
        logic [95:0] cw;
        int cyc, errs;
        info = 64'h0123_4567_89AB_CDEF;
        run_frame(info, 9, 1'b0, cw, cyc, errs);
        tests_run++;
        if (errs !== 2) begin
            tests_failed++;
            $display("FAIL len_err_pulses: got %0d expected 2", errs);
        end
        tests_run++;
        if (cw !== {info, model_parity(info)} || cyc !== 25) begin
            tests_failed++;
            $display("FAIL len_err_frame: got %h in %0d cycles expected %h in 25",
                     cw, cyc, {info, model_parity(info)});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] info;
        logic [95:0] cw;
        int cyc, errs;
        m_ready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 4'hF; s_last = 1'b0;
            #1;
            tests_run++;
            if (s_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL pre_reset_ready beat %0d: got %b expected 1", b, s_ready);
            end
        end
        @(negedge clk);
        s_valid = 1'b0; s_data = '0;
        rst_n   = 1'b0;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || err_len !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b d=%h l=%b e=%b expected all 0", m_valid, m_data, m_last, err_len);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        info = 64'h3C3C_0000_FFFF_8001;
        run_frame(info, 15, 1'b0, cw, cyc, errs);
        tests_run++;
        if (cw !== {info, model_parity(info)}) begin
            tests_failed++;
            $display("FAIL post_reset_frame: got %h expected %h", cw, {info, model_parity(info)});
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] info;
        logic [95:0] cw;
        int cyc, errs;
        for (int f = 0; f < 3; f++) begin
            info = {$urandom, $urandom};
            run_frame(info, 15, f[0], cw, cyc, errs);
            tests_run++;
            if (cw !== {info, model_parity(info)}) begin
                tests_failed++;
                $display("FAIL back_to_back_%0d: got %h expected %h", f, cw, {info, model_parity(info)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_single_bit();
        test_backpressure();
        test_len_err();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
